// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide execution unit.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     sum;

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     sh;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   remv;
`endif

  logic            a_sgn;
  logic            b_sgn;
  logic            sa;
  logic            sb;
  logic            neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] fin;

  // Operand signedness, magnitudes and result sign at accept
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op)
      3'd1:       begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:       a_sgn = 1'b1;
      3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default:    ;
    endcase
    sa    = a_sgn & operand_a[XLEN-1];
    sb    = b_sgn & operand_b[XLEN-1];
    a_abs = sa ? -operand_a : operand_a;
    b_abs = sb ? -operand_b : operand_b;
    neg   = (op[2] & op[1]) ? sa : (sa ^ sb);
  end

  // Divide special cases resolved without iterating
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
`ifdef MULDIV_DIV_EN
    if (op[2] && operand_b == '0) begin
      fast     = 1'b1;
      fast_res = op[1] ? operand_a : '1;
    end else if (op[2] && !op[0] &&
                 operand_a == MINV &&
                 &operand_b) begin
      fast     = 1'b1;
      fast_res = op[1] ? '0 : operand_a;
    end
`else
    fast = op[2];
`endif
  end

  // One shift-add or restoring-divide step
  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} +
             (acc[0] ? {1'b0, a_q} : '0);
    acc_nx = {sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    sh   = acc[2*XLEN-1:XLEN-1];
    diff = sh - {1'b0, b_q};
    if (op_q[2])
      acc_nx = {diff[XLEN] ? sh[XLEN-1:0]
                           : diff[XLEN-1:0],
                acc[XLEN-2:0], ~diff[XLEN]};
`endif
  end

  // Sign fix-up and result selection on the last step
  always_comb begin
    prod_s = neg_q ? -acc_nx : acc_nx;
    fin    = (op_q[1:0] == 2'd0) ?
             prod_s[XLEN-1:0] :
             prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    quo  = acc_nx[XLEN-1:0];
    remv = acc_nx[2*XLEN-1:XLEN];
    if (op_q[2])
      fin = op_q[1] ? (neg_q ? -remv : remv)
                    : (neg_q ? -quo : quo);
`else
    if (op_q[2])
      fin = '0;
`endif
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      a_q          <= '0;
`ifdef MULDIV_DIV_EN
      b_q          <= '0;
`endif
      acc          <= '0;
      result       <= '0;
      rd_out       <= '0;
      result_valid <= 1'b0;
      reg_write    <= 1'b0;
      ready        <= 1'b1;
    end else begin
      result_valid <= 1'b0;
      reg_write    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            rd_out <= rd_in;
            neg_q  <= neg;
            a_q    <= a_abs;
`ifdef MULDIV_DIV_EN
            b_q    <= b_abs;
`endif
            acc    <= {{XLEN{1'b0}},
                       op[2] ? a_abs : b_abs};
            cnt    <= '0;
            ready  <= 1'b0;
            if (fast) begin
              state        <= DONE;
              result       <= fast_res;
              result_valid <= 1'b1;
              reg_write    <= (rd_in != 5'd0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state        <= DONE;
            result       <= fin;
            result_valid <= 1'b1;
            reg_write    <= (rd_out != 5'd0);
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
